seq_control_unit: RTL and testbench
===================================

// Module: seq_control_unit
// PURPOSE
//  Parametrised multi-cycle control unit; successor to the fixed 8-bit CU.
//  Fetches one instruction per ins_req/ins_valid handshake, decodes it, and owns an NREGS x XLEN register file (x0 = 0).
//  Drives the ALU over a req/done handshake and data memory over a req/ready handshake with split rd/wr data (no inout).
//  Sits between instruction memory, alu and ram inside cpu.
// PARAMETERS
//  XLEN    16  datapath/register width; each instruction field is XLEN bits
//  NREGS   16  register count (power of 2, >=2); reg index = field[$clog2(NREGS)-1:0]
//  PC_W    8   program counter width; pc wraps modulo 2**PC_W
// PORTS
//  clk         in   1           clock
//  rst         in   1           reset, synchronous, active-high
//  enable      in   1           0: freeze state, pc and regs; outputs keep current-state values
//  ins_req     out  1           high in FETCH
//  ins_valid   in   1           ins_in valid; sampled only while ins_req=1
//  ins_in      in   4+3*XLEN    {opc[3:0], a, b, c}
//  pc          out  PC_W        address of the instruction being fetched
//  alu_req     out  1           high in EXEC_ALU until alu_done is seen
//  alu_operation out 3          0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor
//  alu_op1/op2 out  XLEN        r[a] and r[b]; stable while alu_req=1
//  alu_done    in   1           alu_res valid this cycle
//  alu_res     in   XLEN        ALU result
//  mem_req     out  1           high in MEM_RD/MEM_WR until mem_ready
//  mem_we      out  1           1 = write (MEM_WR)
//  mem_addr    out  XLEN        memory address
//  mem_wdata   out  XLEN        write data
//  mem_ready   in   1           access completes this cycle; mem_rdata valid on reads
//  mem_rdata   in   XLEN        read data
//  dbg_raddr   in   $clog2(NREGS)  debug register index
//  dbg_rdata   out  XLEN        r[dbg_raddr], combinational
//  halted      out  1           sticky after HLT until reset
//  illegal     out  1           1-cycle pulse on an undefined opcode
// BEHAVIOUR
//  Reset: state FETCH; pc=0; all regs 0; halted=0; illegal=0; ins_req, alu_req, mem_req, mem_we = 0 in the cycle after rst.
//  All transitions below also require enable=1. rst takes priority over enable.
//  FETCH: ins_req=1. On ins_valid: latch opc/a/b/c -> DECODE.
//  DECODE: pc<=pc+1 (wraps) unless overridden below. Then by opc:
//    0 NOP -> FETCH. 1 JMP: pc<=a[PC_W-1:0] -> FETCH.
//    2 ADD, 3 SUB, 4 MUL, 5 DIV, A AND, B ORR, C XOR -> EXEC_ALU.
//    6 BRE: if r[a]!=0 then pc<=b[PC_W-1:0] -> FETCH.
//    7 LD: r[c]<=mem[r[a]] -> MEM_RD. 8 ST: mem[r[a]]<=r[b] -> MEM_WR.
//    9 SET: r[a]<=b -> FETCH. D HLT: halted<=1 -> HALT.
//    E, F: illegal=1 for one cycle -> FETCH (pc still increments).
//  EXEC_ALU: alu_req=1 and operands held. On alu_done: r[c]<=alu_res, then FETCH.
//    A done in the same cycle as req is legal; latency is 1..N cycles.
//  MEM_RD/MEM_WR: mem_req=1; mem_addr=r[a]. For MEM_WR, mem_we=1 and mem_wdata=r[b].
//    On mem_ready: a read captures r[c]<=mem_rdata; both go to FETCH.
//  HALT: terminal. No requests issued. Only rst exits.
//  Writes to x0 are discarded; x0 always reads 0.
//  Minimum latency: NOP/JMP/BRE/SET 2 cycles; ALU/LD/ST 3 cycles plus handshake wait.
//  Reset mid-operation: the outstanding request is abandoned (deasserted next cycle); a late done/ready is ignored.
//  alu_done/mem_ready outside the matching state are ignored. ins_valid outside FETCH is ignored.
// TESTING
//  SET x1,5; SET x2,7; ADD a=1 b=2 c=3, alu_done after 3 cycles with res 12 -> op1=5, op2=7 held while req; dbg x3=12; pc=3
//  BRE a=1 (x1=5) b=0x20 -> pc=0x20; BRE a=0 -> pc increments only
//  ST a=1 b=2 with mem_ready delayed 2 cycles -> mem_we=1, addr=5, wdata=7 held; then LD a=1 c=4 with rdata 0xBEEF -> x4=0xBEEF
//  SET x0,9 -> dbg x0=0; opcode 0xE -> illegal pulses 1 cycle, pc+1; JMP 0xFF then NOP -> pc wraps to 0
//  rst asserted in MEM_RD mid-wait -> next cycle mem_req=0, pc=0, ins_req=1; late mem_ready causes no register write
//  HLT -> halted=1, ins_req stays 0 for 20 cycles; enable=0 during EXEC_ALU -> state and pc frozen, alu_req held

Source files
------------

// File: rtl/seq_control_unit_if.sv
// Handshake bundle between seq_control_unit and its instruction memory, ALU and data memory.
// master is the control unit side, slave is the environment side.
interface seq_control_unit_if #(
    parameter int XLEN = 16,
    parameter int PC_W = 8
);
    logic                   ins_req;
    logic                   ins_valid;
    logic [4+3*XLEN-1:0]    ins_in;
    logic [PC_W-1:0]        pc;

    logic                   alu_req;
    logic [2:0]             alu_operation;
    logic [XLEN-1:0]        alu_op1;
    logic [XLEN-1:0]        alu_op2;
    logic                   alu_done;
    logic [XLEN-1:0]        alu_res;

    logic                   mem_req;
    logic                   mem_we;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic                   mem_ready;
    logic [XLEN-1:0]        mem_rdata;

    modport master (
        output ins_req, pc,
        output alu_req, alu_operation, alu_op1, alu_op2,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  ins_valid, ins_in,
        input  alu_done, alu_res,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  ins_req, pc,
        input  alu_req, alu_operation, alu_op1, alu_op2,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output ins_valid, ins_in,
        output alu_done, alu_res,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit: fetch/decode, NREGS x XLEN register file,
// ALU req/done and data memory req/ready sequencing.
module seq_control_unit #(
    parameter int XLEN  = 16,
    parameter int NREGS = 16,
    parameter int PC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    seq_control_unit_if.master       bus,
    input  logic [$clog2(NREGS)-1:0] dbg_raddr,
    output logic [XLEN-1:0]          dbg_rdata,
    output logic                     halted,
    output logic                     illegal
);
    localparam int RW = $clog2(NREGS);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_DIV = 4'h5;
    localparam logic [3:0] OP_BRE = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_SET = 4'h9;
    localparam logic [3:0] OP_AND = 4'hA;
    localparam logic [3:0] OP_ORR = 4'hB;
    localparam logic [3:0] OP_XOR = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hD;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_ALU,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        opc_q;
    logic [XLEN-1:0]   a_q, b_q, c_q;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic              halted_q;
    logic              illegal_q;

    logic              wr_en;
    logic [RW-1:0]     wr_idx;
    logic [XLEN-1:0]   wr_data;
    logic [RW-1:0]     ra, rb, rc;
    logic [XLEN-1:0]   rd_a, rd_b;
    logic              is_alu;
    logic              unused_fields;

    assign ra   = a_q[RW-1:0];
    assign rb   = b_q[RW-1:0];
    assign rc   = c_q[RW-1:0];
    assign rd_a = regs_q[ra];
    assign rd_b = regs_q[rb];

    // Only the low bits of a/c are consumed; upper bits are don't-care.
    assign unused_fields = ^{a_q, c_q};

    always_comb begin
        is_alu = 1'b0;
        bus.alu_operation = 3'd0;
        unique case (opc_q)
            OP_ADD: begin is_alu = 1'b1; bus.alu_operation = 3'd0; end
            OP_SUB: begin is_alu = 1'b1; bus.alu_operation = 3'd1; end
            OP_MUL: begin is_alu = 1'b1; bus.alu_operation = 3'd2; end
            OP_DIV: begin is_alu = 1'b1; bus.alu_operation = 3'd3; end
            OP_AND: begin is_alu = 1'b1; bus.alu_operation = 3'd4; end
            OP_ORR: begin is_alu = 1'b1; bus.alu_operation = 3'd5; end
            OP_XOR: begin is_alu = 1'b1; bus.alu_operation = 3'd6; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (bus.ins_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu)                state_d = S_EXEC_ALU;
                else if (opc_q == OP_LD)   state_d = S_MEM_RD;
                else if (opc_q == OP_ST)   state_d = S_MEM_WR;
                else if (opc_q == OP_HLT)  state_d = S_HALT;
                else                       state_d = S_FETCH;
            end
            S_EXEC_ALU: begin
                if (bus.alu_done) state_d = S_FETCH;
            end
            S_MEM_RD, S_MEM_WR: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // ins_req is masked while rst is held so no fetch is advertised in reset.
    always_comb begin
        bus.ins_req = 1'b0;
        bus.alu_req = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        unique case (state_q)
            S_FETCH:    bus.ins_req = ~rst;
            S_EXEC_ALU: bus.alu_req = 1'b1;
            S_MEM_RD:   bus.mem_req = 1'b1;
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        wr_en   = 1'b0;
        wr_idx  = rc;
        wr_data = bus.alu_res;
        unique case (state_q)
            S_DECODE: begin
                pc_d = pc_q + 1'b1;
                if (opc_q == OP_JMP) begin
                    pc_d = a_q[PC_W-1:0];
                end else if (opc_q == OP_BRE) begin
                    if (rd_a != '0) pc_d = b_q[PC_W-1:0];
                end else if (opc_q == OP_SET) begin
                    wr_en   = 1'b1;
                    wr_idx  = ra;
                    wr_data = b_q;
                end
            end
            S_EXEC_ALU: begin
                wr_en = bus.alu_done;
            end
            S_MEM_RD: begin
                wr_en   = bus.mem_ready;
                wr_data = bus.mem_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            opc_q     <= OP_NOP;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            illegal_q <= 1'b0;
            if (enable) begin
                pc_q <= pc_d;
                if (state_q == S_FETCH && bus.ins_valid) begin
                    opc_q <= bus.ins_in[3*XLEN+3 -: 4];
                    a_q   <= bus.ins_in[3*XLEN-1 -: XLEN];
                    b_q   <= bus.ins_in[2*XLEN-1 -: XLEN];
                    c_q   <= bus.ins_in[XLEN-1:0];
                end
                if (state_q == S_DECODE && opc_q == OP_HLT) halted_q <= 1'b1;
                if (state_q == S_DECODE && opc_q[3:1] == 3'b111) illegal_q <= 1'b1;
                if (wr_en && wr_idx != '0) regs_q[wr_idx] <= wr_data;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.alu_op1   = rd_a;
    assign bus.alu_op2   = rd_b;
    assign bus.mem_addr  = rd_a;
    assign bus.mem_wdata = rd_b;
    assign dbg_rdata     = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];
    assign halted        = halted_q;
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit with request scoreboards
// for the ALU and data memory handshakes.
module tb_seq_control_unit;
    localparam int XLEN  = 16;
    localparam int NREGS = 16;
    localparam int PC_W  = 8;
    localparam int TMO   = 50;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [3:0]      dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
    logic            halted;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]      op;
        logic            we;
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
    } exp_t;

    exp_t alu_q[$];
    exp_t mem_q[$];

    seq_control_unit_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    seq_control_unit #(
        .XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .bus(bus),
        .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata),
        .halted(halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [2:0] op, input logic we,
                                input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        exp_t e;
        e.op = op;
        e.we = we;
        e.x  = x;
        e.y  = y;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] idx, input logic [XLEN-1:0] exp);
        dbg_raddr = idx;
        #1;
        chk($sformatf("x%0d", idx), 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic wait_ins();
        int n = 0;
        while (bus.ins_req !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n == TMO) chk("ins_req_timeout", 32'(bus.ins_req), 32'd1);
    endtask

    task automatic wait_alu();
        int n = 0;
        while (bus.alu_req !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n == TMO) chk("alu_req_timeout", 32'(bus.alu_req), 32'd1);
    endtask

    task automatic wait_mem();
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n == TMO) chk("mem_req_timeout", 32'(bus.mem_req), 32'd1);
    endtask

    task automatic fetch(input logic [3:0] opc, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
        wait_ins();
        bus.ins_in    = {opc, a, b, c};
        bus.ins_valid = 1'b1;
        @(negedge clk);
        bus.ins_valid = 1'b0;
    endtask

    task automatic alu_pop();
        exp_t e;
        wait_alu();
        e = alu_q.pop_front();
        chk("alu_operation", 32'(bus.alu_operation), 32'(e.op));
        chk("alu_op1", 32'(bus.alu_op1), 32'(e.x));
        chk("alu_op2", 32'(bus.alu_op2), 32'(e.y));
    endtask

    task automatic mem_pop();
        exp_t e;
        wait_mem();
        e = mem_q.pop_front();
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.x));
        if (e.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.y));
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b1;
        dbg_raddr     = '0;
        bus.ins_valid = 1'b0;
        bus.ins_in    = '0;
        bus.alu_done  = 1'b0;
        bus.alu_res   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_ins_req", 32'(bus.ins_req), 32'd0);
        chk("rst_alu_req", 32'(bus.alu_req), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ins_req", 32'(bus.ins_req), 32'd1);

        fetch(4'h9, 16'd1, 16'd5, 16'd0);
        fetch(4'h9, 16'd2, 16'd7, 16'd0);
        alu_q.push_back(mk(3'd0, 1'b0, 16'd5, 16'd7));
        fetch(4'h2, 16'd1, 16'd2, 16'd3);
        alu_pop();
        @(negedge clk);
        chk("add_req_held", 32'(bus.alu_req), 32'd1);
        chk("add_op1_held", 32'(bus.alu_op1), 32'd5);
        @(negedge clk);
        chk("add_op2_held", 32'(bus.alu_op2), 32'd7);
        bus.alu_done = 1'b1;
        bus.alu_res  = 16'd5 + 16'd7;
        @(negedge clk);
        bus.alu_done = 1'b0;
        chk_reg(4'd3, 16'd12);
        chk("add_pc", 32'(bus.pc), 32'd3);

        alu_q.push_back(mk(3'd6, 1'b0, 16'd5, 16'd7));
        fetch(4'hC, 16'd1, 16'd2, 16'd7);
        alu_pop();
        bus.alu_done = 1'b1;
        bus.alu_res  = 16'd5 ^ 16'd7;
        @(negedge clk);
        bus.alu_done = 1'b0;
        chk_reg(4'd7, 16'd2);

        fetch(4'h6, 16'd1, 16'h20, 16'd0);
        @(negedge clk);
        chk("bre_taken_pc", 32'(bus.pc), 32'h20);
        fetch(4'h6, 16'd0, 16'h40, 16'd0);
        @(negedge clk);
        chk("bre_not_taken_pc", 32'(bus.pc), 32'h21);

        mem_q.push_back(mk(3'd0, 1'b1, 16'd5, 16'd7));
        fetch(4'h8, 16'd1, 16'd2, 16'd0);
        mem_pop();
        @(negedge clk);
        chk("st_req_held", 32'(bus.mem_req), 32'd1);
        chk("st_wdata_held", 32'(bus.mem_wdata), 32'd7);
        @(negedge clk);
        chk("st_addr_held", 32'(bus.mem_addr), 32'd5);
        chk("st_we_held", 32'(bus.mem_we), 32'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("st_done_req", 32'(bus.mem_req), 32'd0);

        mem_q.push_back(mk(3'd0, 1'b0, 16'd5, 16'd0));
        fetch(4'h7, 16'd1, 16'd0, 16'd4);
        mem_pop();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk_reg(4'd4, 16'hBEEF);

        fetch(4'h9, 16'd0, 16'd9, 16'd0);
        @(negedge clk);
        chk_reg(4'd0, 16'd0);

        fetch(4'hE, 16'd0, 16'd0, 16'd0);
        chk("illegal_pre", 32'(illegal), 32'd0);
        @(negedge clk);
        chk("illegal_pulse", 32'(illegal), 32'd1);
        chk("illegal_pc", 32'(bus.pc), 32'h25);
        @(negedge clk);
        chk("illegal_clear", 32'(illegal), 32'd0);

        fetch(4'h1, 16'h00FF, 16'd0, 16'd0);
        @(negedge clk);
        chk("jmp_pc", 32'(bus.pc), 32'hFF);
        fetch(4'h0, 16'd0, 16'd0, 16'd0);
        @(negedge clk);
        chk("wrap_pc", 32'(bus.pc), 32'd0);

        mem_q.push_back(mk(3'd0, 1'b0, 16'd5, 16'd0));
        fetch(4'h7, 16'd1, 16'd0, 16'd5);
        mem_pop();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
        chk("abort_pc", 32'(bus.pc), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ins_req", 32'(bus.ins_req), 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1234;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk_reg(4'd5, 16'd0);
        chk_reg(4'd4, 16'd0);
        chk("late_ready_ins_req", 32'(bus.ins_req), 32'd1);

        fetch(4'hD, 16'd0, 16'd0, 16'd0);
        @(negedge clk);
        chk("halted_set", 32'(halted), 32'd1);
        bus.ins_in    = {4'h9, 16'd1, 16'd5, 16'd0};
        bus.ins_valid = 1'b1;
        repeat (20) begin
            chk("halt_ins_req", 32'(bus.ins_req), 32'd0);
            @(negedge clk);
        end
        bus.ins_valid = 1'b0;
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_mem_req", 32'(bus.mem_req), 32'd0);
        chk_reg(4'd1, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("halt_cleared", 32'(halted), 32'd0);

        fetch(4'h9, 16'd1, 16'd5, 16'd0);
        fetch(4'h9, 16'd2, 16'd7, 16'd0);
        alu_q.push_back(mk(3'd2, 1'b0, 16'd5, 16'd7));
        fetch(4'h4, 16'd1, 16'd2, 16'd6);
        alu_pop();
        enable       = 1'b0;
        bus.alu_done = 1'b1;
        bus.alu_res  = 16'd5 * 16'd7;
        repeat (3) begin
            @(negedge clk);
            chk("freeze_alu_req", 32'(bus.alu_req), 32'd1);
            chk("freeze_pc", 32'(bus.pc), 32'd3);
            chk_reg(4'd6, 16'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        chk_reg(4'd6, 16'd35);
        chk("resume_ins_req", 32'(bus.ins_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
